// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its surroundings.
// master = scanner side (drives columns and key events, senses rows).
// slave  = board/user side (drives rows, observes columns and key events).
interface keypad_scanner_if;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  modport master (
    output COL,
    output key_code,
    output key_valid,
    output key_down,
    output multi_key,
    input  ROW
  );

  modport slave (
    input  COL,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_key,
    output ROW
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync, whole-frame debounce, single-key decode.
// Latency: key_valid one cycle after the frame that completes the debounce.
// No backpressure: key_valid is a one-cycle strobe, key_code holds until the next accepted press.
module keypad_scanner #(
  parameter logic [18:0] SCAN_DIV       = 19'd14000,
  parameter int          DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, HELD, BLOCKED} state_t;

  logic [18:0] div;
  logic        scan_en;
  logic [1:0]  col_idx;
  logic [3:0]  col_q;
  logic [3:0]  row_s1, row_s2;
  logic [3:0]  rows_p;
  logic [15:0] cur_frame, prev_frame, new_frame;
  logic [3:0]  stable_cnt;
  logic        frame_done, same_frame, accept;

  state_t      state, state_n;
  logic [3:0]  key_code_q, key_code_n;
  logic        key_valid_q, key_valid_n;
  logic        key_down_q, key_down_n;
  logic        multi_q, multi_n;
  logic [3:0]  held_idx, held_idx_n;
  logic        one_key;
  logic [3:0]  key_idx;

  // Hex code for frame bit index 4*col+row.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
      4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
      4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
      4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
      4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
      4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
      4'd14: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  assign scan_en    = (div == SCAN_DIV);
  assign rows_p     = ~row_s2;
  assign frame_done = scan_en && (col_idx == 2'd3);
  assign new_frame  = {rows_p, cur_frame[11:0]};
  assign same_frame = (new_frame == prev_frame);
  assign accept     = frame_done && same_frame && (stable_cnt == DB - 4'd1);

  // Column dwell divider: scan_en fires once every SCAN_DIV+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div <= '0;
    else        div <= scan_en ? '0 : div + 19'd1;
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= kp.ROW;
      row_s2 <= row_s1;
    end
  end

  // Capture the settled rows of the driven column, then advance the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_idx   <= 2'd0;
      col_q     <= 4'b1110;
      cur_frame <= '0;
    end else if (scan_en) begin
      cur_frame[{col_idx, 2'b00} +: 4] <= rows_p;
      col_idx <= col_idx + 2'd1;
      col_q   <= ~(4'b0001 << (col_idx + 2'd1));
    end
  end

  // Frame debounce: count consecutive identical frames, saturating so accept fires once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_frame <= '0;
      stable_cnt <= '0;
    end else if (frame_done) begin
      prev_frame <= new_frame;
      if (!same_frame)       stable_cnt <= '0;
      else if (stable_cnt != DB) stable_cnt <= stable_cnt + 4'd1;
    end
  end

  // Classify the candidate frame: exactly one key, and which one.
  always_comb begin
    one_key = (new_frame != '0) && ((new_frame & (new_frame - 16'd1)) == '0);
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (new_frame[i]) key_idx = 4'(i);
    end
  end

  // Key FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_q     <= 1'b0;
      held_idx    <= '0;
    end else begin
      state       <= state_n;
      key_code_q  <= key_code_n;
      key_valid_q <= key_valid_n;
      key_down_q  <= key_down_n;
      multi_q     <= multi_n;
      held_idx    <= held_idx_n;
    end
  end

  // Next-state logic: only accepted frames move the FSM.
  always_comb begin
    state_n     = state;
    key_code_n  = key_code_q;
    key_valid_n = 1'b0;
    key_down_n  = key_down_q;
    multi_n     = multi_q;
    held_idx_n  = held_idx;
    if (accept) begin
      case (state)
        IDLE: begin
          if (one_key) begin
            key_code_n  = key_map(key_idx);
            key_valid_n = 1'b1;
            key_down_n  = 1'b1;
            held_idx_n  = key_idx;
            state_n     = HELD;
          end else if (new_frame != '0) begin
            multi_n = 1'b1;
            state_n = BLOCKED;
          end
        end
        HELD: begin
          if (new_frame == '0) begin
            key_down_n = 1'b0;
            state_n    = IDLE;
          end else if (new_frame != (16'd1 << held_idx)) begin
            key_down_n = 1'b0;
            multi_n    = 1'b1;
            state_n    = BLOCKED;
          end
        end
        default: begin
          if (new_frame == '0) begin
            multi_n = 1'b0;
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  assign kp.COL       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
  assign kp.multi_key = multi_q;

endmodule
